// File: rtl/lfsr_delay_gen_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_delay_pkg
// Shared constants, state encoding and LFSR helpers for the pseudo-random
// delay generator that feeds timeAdj of the 8-bit pulse timer.
//   LFSR_TAPS : Fibonacci tap mask for taps 8,6,5,4 (q[7],q[5],q[4],q[3])
//   SEED_SAFE : substitute for an all-zero seed (lock-up state of the LFSR)
//   DIV_STEPS : number of restoring shift-subtract iterations per result
//   stateT    : control FSM states
// -----------------------------------------------------------------------------
package lfsr_delay_pkg;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] SEED_SAFE = 8'h01;
    localparam int         DIV_STEPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } stateT;

    // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [7:0] lfsrNext(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

    // All-zero would lock the LFSR, so it is replaced by SEED_SAFE.
    function automatic logic [7:0] seedFix(input logic [7:0] s);
        return (s == 8'h00) ? SEED_SAFE : s;
    endfunction

endpackage

// File: rtl/lfsr_delay_gen_div8.sv
// -----------------------------------------------------------------------------
// mod_div8_seq
// Fixed-latency restoring remainder: dividend % divisor, MSB first,
// DIV_STEPS iterations after start.
// Ports:
//   pulseClk  : clock, rising edge
//   rst       : synchronous, active-low reset (iteration counter only)
//   start     : load operands; iterations begin on the following edges
//   dividend  : 8-bit dividend
//   divisor   : 9-bit divisor, 1..256
//   done      : high during the cycle whose closing edge performs the final
//               iteration; remainder is final from the next cycle on
//   remainder : 9-bit running remainder (always < divisor when final)
// -----------------------------------------------------------------------------
module mod_div8_seq
    import lfsr_delay_pkg::*;
(
    input  logic       pulseClk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [8:0] divisor,
    output logic       done,
    output logic [8:0] remainder
);

    logic [3:0] stepCnt;
    logic [7:0] quoShift;
    logic [8:0] divReg;
    logic [8:0] remReg;
    logic [9:0] trial;

    // Remainder stays below divisor (<= 256), so the shifted trial value is
    // below 512 and ten bits are enough.
    assign trial = {remReg, quoShift[7]};

    always_ff @(posedge pulseClk) begin
        if (!rst) begin
            stepCnt <= 4'd0;
        end else if (start) begin
            stepCnt <= 4'(DIV_STEPS);
        end else if (stepCnt != 4'd0) begin
            stepCnt <= stepCnt - 4'd1;
        end
    end

    always_ff @(posedge pulseClk) begin
        if (start) begin
            remReg   <= 9'd0;
            quoShift <= dividend;
            divReg   <= divisor;
        end else if (stepCnt != 4'd0) begin
            quoShift <= {quoShift[6:0], 1'b0};
            if (trial >= {1'b0, divReg}) begin
                remReg <= 9'(trial - {1'b0, divReg});
            end else begin
                remReg <= trial[8:0];
            end
        end
    end

    assign done      = (stepCnt == 4'd1);
    assign remainder = remReg;

endmodule

// File: rtl/lfsr_delay_gen.sv
// -----------------------------------------------------------------------------
// lfsr_delay_gen
// Pseudo-random delay source for the pulse timer. Each rising edge of the
// timer pulse advances an 8-bit maximal-length LFSR and reduces the new value
// into [minDelay, maxDelay] with a fixed 10-cycle sequential modulo.
// Parameters:
//   SEED_DEFAULT : LFSR value after reset (zero is replaced by 8'h01)
// Ports:
//   pulseClk  : clock, rising edge
//   rst       : synchronous, active-low reset
//   enable    : gates triggers; a running computation always completes
//   pulseIn   : timer pulse; a 0->1 edge is a trigger
//   seedLoad  : load seed into the LFSR, abort computation, clear overrun
//   seed      : LFSR load value (zero replaced by 8'h01)
//   minDelay  : lower window bound (captured at trigger)
//   maxDelay  : upper window bound (captured at trigger)
//   timeAdj   : delay value to the timer, held between updates
//   adjValid  : one-cycle strobe, timeAdj just updated
//   busy      : computation in progress
//   overrun   : sticky, a trigger arrived while busy
// -----------------------------------------------------------------------------
module lfsr_delay_gen
    import lfsr_delay_pkg::*;
#(
    parameter logic [7:0] SEED_DEFAULT = 8'h01
) (
    input  logic       pulseClk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pulseIn,
    input  logic       seedLoad,
    input  logic [7:0] seed,
    input  logic [7:0] minDelay,
    input  logic [7:0] maxDelay,
    output logic [7:0] timeAdj,
    output logic       adjValid,
    output logic       busy,
    output logic       overrun
);

    stateT      state;
    stateT      stateNext;
    logic [7:0] lfsr;
    logic [7:0] lfsrAdv;
    logic       pulseInD;
    logic       trigger;
    logic [7:0] minLat;
    logic [8:0] divLat;
    logic       divStart;
    logic       divDone;
    logic [8:0] divRem;

    assign trigger  = pulseIn & ~pulseInD & enable;
    assign lfsrAdv  = lfsrNext(lfsr);
    assign divStart = (state == STEP);
    assign busy     = (state != IDLE);

    always_ff @(posedge pulseClk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (trigger) stateNext = STEP;
            STEP: stateNext = DIV;
            DIV:  if (divDone) stateNext = OUT;
            OUT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // A seed load aborts whatever is in flight.
        if (seedLoad) begin
            stateNext = IDLE;
        end
    end

    // Window capture: later changes of minDelay/maxDelay do not disturb the
    // running computation. An inverted window collapses to divisor 1, which
    // yields remainder 0 and therefore timeAdj = minDelay.
    always_ff @(posedge pulseClk) begin
        if (state == IDLE && trigger && !seedLoad) begin
            minLat <= minDelay;
            if (maxDelay >= minDelay) begin
                divLat <= {1'b0, maxDelay} - {1'b0, minDelay} + 9'd1;
            end else begin
                divLat <= 9'd1;
            end
        end
    end

    always_ff @(posedge pulseClk) begin
        if (!rst) begin
            lfsr     <= seedFix(SEED_DEFAULT);
            pulseInD <= 1'b0;
            timeAdj  <= 8'h00;
            adjValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pulseInD <= pulseIn;
            adjValid <= 1'b0;
            if (seedLoad) begin
                lfsr    <= seedFix(seed);
                overrun <= 1'b0;
            end else begin
                if (state == STEP) begin
                    lfsr <= lfsrAdv;
                end
                if (trigger && state != IDLE) begin
                    overrun <= 1'b1;
                end
                // rem < div, so min + rem never exceeds maxDelay.
                if (state == OUT) begin
                    timeAdj  <= minLat + divRem[7:0];
                    adjValid <= 1'b1;
                end
            end
        end
    end

    // Divider is loaded in STEP with the freshly advanced LFSR value.
    mod_div8_seq uDiv (
        .pulseClk  (pulseClk),
        .rst       (rst),
        .start     (divStart),
        .dividend  (lfsrAdv),
        .divisor   (divLat),
        .done      (divDone),
        .remainder (divRem)
    );

endmodule

// File: tb/tb_lfsr_delay_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_delay_gen
// Self-checking bench for lfsr_delay_gen with a behavioural LFSR / window
// model and randomized windows and seeds.
// -----------------------------------------------------------------------------
module tb_lfsr_delay_gen;

    logic       pulseClk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pulseIn;
    logic       seedLoad;
    logic [7:0] seed;
    logic [7:0] minDelay;
    logic [7:0] maxDelay;
    logic [7:0] timeAdj;
    logic       adjValid;
    logic       busy;
    logic       overrun;

    int nChecks = 0;
    int nErrors = 0;
    int modelLfsr;

    lfsr_delay_gen #(.SEED_DEFAULT(8'h01)) dut (
        .pulseClk (pulseClk),
        .rst      (rst),
        .enable   (enable),
        .pulseIn  (pulseIn),
        .seedLoad (seedLoad),
        .seed     (seed),
        .minDelay (minDelay),
        .maxDelay (maxDelay),
        .timeAdj  (timeAdj),
        .adjValid (adjValid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 pulseClk = ~pulseClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference LFSR: x^8 + x^6 + x^5 + x^4 Fibonacci, by plain arithmetic.
    function automatic int lfsrStep(input int q);
        int fb;
        fb = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
        return ((q << 1) & 255) | fb;
    endfunction

    function automatic int expectAdj(input int q, input int mn, input int mx);
        if (mx < mn) return mn;
        return mn + (q % (mx - mn + 1));
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pulseClk);
        #1;
    endtask

    task automatic loadSeed(input int v);
        seedLoad = 1'b1;
        seed     = 8'(v);
        tick();
        seedLoad  = 1'b0;
        modelLfsr = (v == 0) ? 1 : v;
    endtask

    // One trigger with window [mn,mx]; the window inputs are scrambled right
    // after capture. Checks latency and result against the model.
    task automatic fireCheck(input string tag, input int mn, input int mx);
        int cycles;
        minDelay = 8'(mn);
        maxDelay = 8'(mx);
        pulseIn  = 1'b1;
        tick();
        pulseIn  = 1'b0;
        minDelay = 8'($urandom);
        maxDelay = 8'($urandom);
        cycles   = 0;
        while (adjValid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        modelLfsr = lfsrStep(modelLfsr);
        checkVal({tag, "_latency"}, cycles, 10);
        checkVal({tag, "_timeAdj"}, timeAdj, expectAdj(modelLfsr, mn, mx));
    endtask

    task automatic countValids(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (adjValid === 1'b1) cnt++;
        end
    endtask

    initial begin
        int plan[4] = '{12, 14, 18, 16};
        int cnt;
        int saved;
        int startSeed;
        int mn;
        int mx;

        rst = 1'b0; enable = 1'b1; pulseIn = 1'b0; seedLoad = 1'b0;
        seed = 8'h00; minDelay = 8'h00; maxDelay = 8'h00;
        repeat (3) tick();
        checkVal("rst_timeAdj", timeAdj, 0);
        checkVal("rst_adjValid", adjValid, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_overrun", overrun, 0);
        rst = 1'b1;
        tick();
        modelLfsr = 1;

        // Default seed after reset, full window exposes the LFSR value.
        fireCheck("dflt", 0, 255);
        checkVal("dflt_value", timeAdj, 2);

        // Window 10..20 from seed 01.
        loadSeed(1);
        for (int i = 0; i < 4; i++) begin
            fireCheck("win", 10, 20);
            checkVal("win_plan", timeAdj, plan[i]);
            repeat (9) tick();
        end

        // Zero seed forced to 01.
        loadSeed(0);
        fireCheck("seed0", 0, 255);
        checkVal("seed0_value", timeAdj, 2);

        // Inverted window.
        fireCheck("inv", 50, 40);
        checkVal("inv_value", timeAdj, 50);

        // Disabled: edge ignored.
        enable  = 1'b0;
        pulseIn = 1'b1;
        tick();
        pulseIn = 1'b0;
        checkVal("dis_busy", busy, 0);
        countValids(15, cnt);
        checkVal("dis_valids", cnt, 0);
        enable = 1'b1;

        // Overrun: second edge 4 cycles after the trigger.
        minDelay = 8'd3; maxDelay = 8'd200;
        pulseIn = 1'b1;
        tick();
        pulseIn = 1'b0;
        repeat (3) tick();
        pulseIn = 1'b1;
        tick();
        pulseIn = 1'b0;
        countValids(20, cnt);
        modelLfsr = lfsrStep(modelLfsr);
        checkVal("ovr_valids", cnt, 1);
        checkVal("ovr_timeAdj", timeAdj, expectAdj(modelLfsr, 3, 200));
        checkVal("ovr_flag", overrun, 1);
        loadSeed(8'hA5);
        checkVal("ovr_clear", overrun, 0);

        // Abort by seedLoad at T+5.
        saved = int'(timeAdj);
        pulseIn = 1'b1;
        tick();
        pulseIn = 1'b0;
        repeat (4) tick();
        seedLoad = 1'b1;
        seed = 8'h3C;
        tick();
        seedLoad = 1'b0;
        modelLfsr = 8'h3C;
        checkVal("abt_busy", busy, 0);
        countValids(15, cnt);
        checkVal("abt_valids", cnt, 0);
        checkVal("abt_timeAdj", timeAdj, saved);
        fireCheck("abt_reseed", 0, 255);

        // Abort by reset at T+5.
        pulseIn = 1'b1;
        tick();
        pulseIn = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        modelLfsr = 1;
        checkVal("rabt_timeAdj", timeAdj, 0);
        checkVal("rabt_adjValid", adjValid, 0);
        checkVal("rabt_busy", busy, 0);
        checkVal("rabt_overrun", overrun, 0);
        countValids(15, cnt);
        checkVal("rabt_valids", cnt, 0);

        // Random windows over a full LFSR period.
        startSeed = $urandom_range(1, 255);
        loadSeed(startSeed);
        for (int i = 0; i < 254; i++) begin
            mn = $urandom_range(0, 255);
            mx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                             : $urandom_range(mn, 255);
            fireCheck("rnd", mn, mx);
        end
        fireCheck("period", 0, 255);
        checkVal("period_seed", timeAdj, startSeed);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/lfsr_delay_gen.md
# lfsr_delay_gen

Pseudo-random delay source feeding `timeAdj` of the reconfigurable 8-bit pulse timer. The block holds an 8-bit maximal-length LFSR and advances it once per timer output pulse. It reduces each new value into the programmable window [minDelay, maxDelay] with a fixed-latency sequential modulo. The timer therefore fires at randomised but bounded intervals.

## Interface
Parameters:
- SEED_DEFAULT, 8'h01, LFSR value after reset; a zero value is forced to 8'h01.

Ports:
- pulseClk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- enable  in  1  when 0, triggers are ignored; an in-flight computation still completes
- pulseIn  in  1  timer's pulseROut; a 0→1 edge is a trigger
- seedLoad  in  1  synchronous LFSR load strobe
- seed  in  8  load value; 8'h00 is replaced by 8'h01
- minDelay  in  8  lower window bound
- maxDelay  in  8  upper window bound
- timeAdj  out  8  delay value to the timer, held stable between updates
- adjValid  out  1  one-cycle strobe, timeAdj just updated
- busy  out  1  computation in progress
- overrun  out  1  sticky; a trigger arrived while busy

## Operation
- Reset (rst=0 at an edge) sets:
  - lfsr=SEED_DEFAULT (or 8'h01 if zero)
  - timeAdj=8'h00, adjValid=0, busy=0, overrun=0
  - pulse-edge history=0, state=IDLE
- LFSR: Fibonacci, taps 8,6,5,4.
  - fb = q[7]^q[5]^q[4]^q[3]
  - next = {q[6:0], fb}
  - Period 255; 8'h00 never reached.
- Trigger = pulseIn & ~pulseIn_d & enable, where pulseIn_d is pulseIn registered.
- States:
  - IDLE → STEP on trigger. On the transition, latch min=minDelay and div=(maxDelay≥minDelay) ? (maxDelay−minDelay+1) : 1. div is 9 bits, range 1..256.
  - STEP: advance LFSR, load divider with the new LFSR value, → DIV.
  - DIV: exactly 8 restoring shift-subtract iterations (MSB first) on the 9-bit remainder, → OUT.
  - OUT: timeAdj ← (min + rem)[7:0]; adjValid=1; → IDLE.
- Arithmetic: rem < div, so min+rem ≤ maxDelay ≤ 255 and no overflow is possible. If maxDelay < minDelay, the result is timeAdj=minDelay.
- busy=1 in STEP, DIV and OUT.
- A trigger while busy is dropped and sets overrun.
- seedLoad has top priority, from any state:
  - lfsr ← seed (0→1); state → IDLE, aborting any computation
  - overrun cleared; timeAdj unchanged; adjValid=0
- minDelay/maxDelay changes after the trigger capture do not affect the running computation.

## Timing
- Trigger sampled at edge T.
- Edge T+1: STEP, LFSR advanced.
- Edges T+2..T+9: DIV.
- Edge T+10: timeAdj updated, adjValid high for the cycle after T+10.
- Total latency: 10 cycles, fixed and independent of window.
- Earliest next accepted trigger: edge T+11.
- The timer samples timeAdj in the cycle its pulse goes high. A new value is therefore used one timer period after the pulse that produced it, which is intentional.
- The minimum timer period (3 cycles) is shorter than the latency. Overrun occurs for timer settings below 11 and is acceptable: timeAdj simply holds its previous value.
- rst or seedLoad mid-computation: state is IDLE on the next edge and no adjValid is issued.

## Structure
- Package `lfsr_delay_pkg` holds:
  - tap mask constant 8'hB8
  - SEED_SAFE = 8'h01
  - DIV_STEPS = 8
  - state enum {IDLE, STEP, DIV, OUT}
- Sub-module `mod_div8_seq`: 8-bit dividend, 9-bit divisor, start/done, 8-cycle restoring remainder. It is instantiated once.
- The LFSR, edge detector, window capture and output registers stay in the top level.

## Test plan
- Window 10..20: after reset, seedLoad seed=8'h01. Four triggers spaced 20 cycles apart give timeAdj=12, 14, 18, 16 (LFSR 02, 04, 08, 11). Each adjValid occurs 10 cycles after its trigger.
- Seed zero: seedLoad seed=8'h00, then trigger with window 0..255 → timeAdj=8'h02 (LFSR forced to 01 then advanced).
- Inverted window: min=50, max=40, trigger → timeAdj=50.
- Overrun: trigger, then a second pulseIn edge 4 cycles later → second edge ignored, overrun=1, one adjValid only. seedLoad then clears overrun.
- Abort: trigger, then seedLoad at T+5 → no adjValid, timeAdj unchanged, busy=0 at T+6. Also assert rst at T+5 → all outputs at reset values.
- Closed loop with the timer, timeAdj window 5..15, 255 pulses: every timer period lies within [5+c, 15+c] for the timer's fixed overhead c, and the LFSR returns to its start value after 255 advances.
